// File: rtl/attack_object_position_control.sv
`default_nettype none
// ============================================================================
// Module      : attack_object_position_control
// Description : Holds one attack object for the renderer and collision check.
//               A descriptor is latched from the ROM reader through the
//               sync_attack_position / update_attack_position handshake. The
//               object then shows for WARN_TICKS frames without collision,
//               moves once per frame_tick, and is retired by its lifetime
//               timer and/or by reaching a screen edge, as destroy_trigger
//               selects.
// Ports       : clk, reset (sync, active-high)
//               frame_tick             - one-cycle pulse per video frame
//               sync_attack_position   - low = reader has a descriptor ready
//               update_attack_position - ack back to reader
//               types, colider_type, movement_direction, speed, pos_x, pos_y,
//               w, h, destroy_time, destroy_trigger - descriptor inputs
//               obj_x, obj_y, obj_w, obj_h, obj_type, obj_colider,
//               obj_visible, obj_collide_en - object state to the renderer
// Revision    : 1.0 - initial release
// ============================================================================
module attack_object_position_control #(
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int WARN_TICKS    = 8,
   parameter int DESTROY_SCALE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       sync_attack_position,
   output logic       update_attack_position,
   input  logic [4:0] types,
   input  logic [1:0] colider_type,
   input  logic [2:0] movement_direction,
   input  logic [4:0] speed,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   input  logic [9:0] w,
   input  logic [9:0] h,
   input  logic [7:0] destroy_time,
   input  logic [1:0] destroy_trigger,
   output logic [9:0] obj_x,
   output logic [9:0] obj_y,
   output logic [9:0] obj_w,
   output logic [9:0] obj_h,
   output logic [4:0] obj_type,
   output logic [1:0] obj_colider,
   output logic       obj_visible,
   output logic       obj_collide_en
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_WARN   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   // Counter wide enough to hold WARN_TICKS-1.
   localparam int                c_WCW       = (WARN_TICKS > 2) ? $clog2(WARN_TICKS) : 1;
   localparam logic [c_WCW-1:0]  c_WARN_LAST = (WARN_TICKS > 0) ? c_WCW'(WARN_TICKS - 1) : '0;
   localparam logic [12:0]       c_SCALE     = 13'(DESTROY_SCALE);
   localparam logic [10:0]       c_SCREEN_W  = 11'(SCREEN_W);
   localparam logic [10:0]       c_SCREEN_H  = 11'(SCREEN_H);

   localparam logic [1:0] c_TRIG_TIMER = 2'd0;
   localparam logic [1:0] c_TRIG_EDGE  = 2'd1;
   localparam logic [1:0] c_TRIG_NEVER = 2'd2;
   localparam logic [1:0] c_TRIG_BOTH  = 2'd3;

   state_t            r_state;
   logic [2:0]        r_dir;
   logic [4:0]        r_speed;
   logic [9:0]        r_start_x;
   logic [9:0]        r_start_y;
   logic [7:0]        r_dtime;
   logic [1:0]        r_trig;
   logic [12:0]       r_life;
   logic [c_WCW-1:0]  r_warn_cnt;
   logic              r_start_clamped;

   logic [10:0]        w_max_x;
   logic [10:0]        w_max_y;
   logic [10:0]        w_ld_x;
   logic [10:0]        w_ld_y;
   logic signed [10:0] w_step;
   logic signed [10:0] w_nx;
   logic signed [10:0] w_ny;
   logic [10:0]        w_mx;
   logic [10:0]        w_my;
   logic               w_moving;
   logic               w_edge_hit;
   logic               w_timer_exp;
   logic               w_retire;
   logic               w_new_desc;

   // Clamp a signed coordinate into [0, maxv]. Returns {fired, value}.
   function automatic logic [10:0] f_clamp(input logic signed [10:0] v,
                                           input logic [10:0]        maxv);
      if (v < 0)
         return {1'b1, 10'd0};
      else if ($unsigned(v) > maxv)
         return {1'b1, maxv[9:0]};
      else
         return {1'b0, v[9:0]};
   endfunction

   // Oversized objects pin to 0 on that axis instead of going negative.
   assign w_max_x = ({1'b0, obj_w} >= c_SCREEN_W) ? 11'd0 : (c_SCREEN_W - {1'b0, obj_w});
   assign w_max_y = ({1'b0, obj_h} >= c_SCREEN_H) ? 11'd0 : (c_SCREEN_H - {1'b0, obj_h});

   assign w_ld_x = f_clamp($signed({1'b0, r_start_x}), w_max_x);
   assign w_ld_y = f_clamp($signed({1'b0, r_start_y}), w_max_y);

   assign w_step = $signed({6'd0, r_speed});

   always_comb begin
      w_nx = $signed({1'b0, obj_x});
      w_ny = $signed({1'b0, obj_y});
      case (r_dir)
         3'd1: w_ny = w_ny - w_step;                                // U
         3'd2: w_ny = w_ny + w_step;                                // D
         3'd3: w_nx = w_nx - w_step;                                // L
         3'd4: w_nx = w_nx + w_step;                                // R
         3'd5: begin w_nx = w_nx - w_step; w_ny = w_ny - w_step; end // UL
         3'd6: begin w_nx = w_nx + w_step; w_ny = w_ny - w_step; end // UR
         3'd7: begin w_nx = w_nx + w_step; w_ny = w_ny + w_step; end // DR
         default: ;
      endcase
   end

   assign w_mx = f_clamp(w_nx, w_max_x);
   assign w_my = f_clamp(w_ny, w_max_y);

   // A stationary object can only hit an edge if it was spawned outside
   // the playfield and pulled back in during LOAD.
   assign w_moving    = (r_speed != 5'd0) && (r_dir != 3'd0);
   assign w_edge_hit  = w_moving ? (w_mx[10] | w_my[10]) : r_start_clamped;
   assign w_timer_exp = (r_dtime != 8'd0) && (r_life == 13'd1);

   always_comb begin
      w_retire = 1'b0;
      case (r_trig)
         c_TRIG_TIMER: w_retire = w_timer_exp;
         c_TRIG_EDGE:  w_retire = w_edge_hit;
         c_TRIG_BOTH:  w_retire = w_timer_exp | w_edge_hit;
         c_TRIG_NEVER: w_retire = 1'b0;
         default:      w_retire = 1'b0;
      endcase
   end

   // Reader presents a descriptor and the previous ack has been released.
   assign w_new_desc = !sync_attack_position && !update_attack_position;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state                <= ST_IDLE;
         update_attack_position <= 1'b0;
         r_dir                  <= '0;
         r_speed                <= '0;
         r_start_x              <= '0;
         r_start_y              <= '0;
         r_dtime                <= '0;
         r_trig                 <= '0;
         r_life                 <= '0;
         r_warn_cnt             <= '0;
         r_start_clamped        <= 1'b0;
         obj_x                  <= '0;
         obj_y                  <= '0;
         obj_w                  <= '0;
         obj_h                  <= '0;
         obj_type               <= '0;
         obj_colider            <= '0;
         obj_visible            <= 1'b0;
         obj_collide_en         <= 1'b0;
      end else begin
         if (update_attack_position && sync_attack_position)
            update_attack_position <= 1'b0;

         if (w_new_desc) begin
            // Handshake pre-empts whatever the object was doing, including
            // a coincident frame_tick.
            obj_type               <= types;
            obj_colider            <= colider_type;
            obj_w                  <= w;
            obj_h                  <= h;
            r_dir                  <= movement_direction;
            r_speed                <= speed;
            r_start_x              <= pos_x;
            r_start_y              <= pos_y;
            r_dtime                <= destroy_time;
            r_trig                 <= destroy_trigger;
            update_attack_position <= 1'b1;
            obj_visible            <= 1'b0;
            obj_collide_en         <= 1'b0;
            r_state                <= ST_LOAD;
         end else begin
            case (r_state)
               ST_IDLE: ;

               ST_LOAD: begin
                  obj_x           <= w_ld_x[9:0];
                  obj_y           <= w_ld_y[9:0];
                  r_start_clamped <= w_ld_x[10] | w_ld_y[10];
                  obj_visible     <= 1'b1;
                  obj_collide_en  <= 1'b0;
                  r_warn_cnt      <= '0;
                  r_life          <= {5'd0, r_dtime} * c_SCALE;
                  if (WARN_TICKS == 0) begin
                     obj_collide_en <= 1'b1;
                     r_state        <= ST_ACTIVE;
                  end else begin
                     r_state        <= ST_WARN;
                  end
               end

               ST_WARN: begin
                  if (frame_tick) begin
                     r_warn_cnt <= r_warn_cnt + 1'b1;
                     if (r_warn_cnt == c_WARN_LAST) begin
                        obj_collide_en <= 1'b1;
                        r_state        <= ST_ACTIVE;
                     end
                  end
               end

               ST_ACTIVE: begin
                  if (frame_tick) begin
                     obj_x <= w_mx[9:0];
                     obj_y <= w_my[9:0];
                     if (r_life != 13'd0)
                        r_life <= r_life - 13'd1;
                     // Retirement uses the position from this same tick.
                     if (w_retire) begin
                        obj_visible    <= 1'b0;
                        obj_collide_en <= 1'b0;
                        r_state        <= ST_IDLE;
                     end
                  end
               end

               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_attack_object_position_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_attack_object_position_control
// Description : Directed self-checking bench for
//               attack_object_position_control. Per-frame expectations go
//               through a scoreboard queue: pushed when the tick is driven,
//               popped and compared once the DUT has clocked it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attack_object_position_control;

   localparam int WARN_TICKS = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       sync_attack_position = 1'b1;
   logic       update_attack_position;
   logic [4:0] types = '0;
   logic [1:0] colider_type = '0;
   logic [2:0] movement_direction = '0;
   logic [4:0] speed = '0;
   logic [9:0] pos_x = '0;
   logic [9:0] pos_y = '0;
   logic [9:0] w = '0;
   logic [9:0] h = '0;
   logic [7:0] destroy_time = '0;
   logic [1:0] destroy_trigger = '0;
   logic [9:0] obj_x, obj_y, obj_w, obj_h;
   logic [4:0] obj_type;
   logic [1:0] obj_colider;
   logic       obj_visible, obj_collide_en;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct {
      string      tag;
      logic [9:0] x;
      logic [9:0] y;
      logic       vis;
      logic       col;
   } exp_t;

   exp_t sb[$];

   attack_object_position_control #(
      .SCREEN_W(640), .SCREEN_H(480), .WARN_TICKS(WARN_TICKS), .DESTROY_SCALE(4)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .sync_attack_position(sync_attack_position),
      .update_attack_position(update_attack_position),
      .types(types), .colider_type(colider_type),
      .movement_direction(movement_direction), .speed(speed),
      .pos_x(pos_x), .pos_y(pos_y), .w(w), .h(h),
      .destroy_time(destroy_time), .destroy_trigger(destroy_trigger),
      .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
      .obj_type(obj_type), .obj_colider(obj_colider),
      .obj_visible(obj_visible), .obj_collide_en(obj_collide_en)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_desc(input logic [4:0] t, input logic [1:0] c, input logic [2:0] d,
                           input logic [4:0] s, input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] ww, input logic [9:0] hh,
                           input logic [7:0] dt, input logic [1:0] tr);
      types = t; colider_type = c; movement_direction = d; speed = s;
      pos_x = x; pos_y = y; w = ww; h = hh; destroy_time = dt; destroy_trigger = tr;
   endtask

   // Full handshake: sync low three cycles, then high. with_tick drives a
   // frame_tick on the cycle the descriptor is taken; prev_x is the x that
   // must survive that tick.
   task automatic handshake(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                            input bit with_tick, input logic [9:0] prev_x);
      sync_attack_position = 1'b0;
      frame_tick = with_tick;
      step();
      frame_tick = 1'b0;
      chk({tag, "_ack1"}, update_attack_position, 1);
      chk({tag, "_type"}, obj_type, types);
      chk({tag, "_col"},  obj_colider, colider_type);
      chk({tag, "_w"},    obj_w, w);
      chk({tag, "_h"},    obj_h, h);
      if (with_tick) chk({tag, "_tick_ignored"}, obj_x, prev_x);
      step();
      chk({tag, "_ack2"}, update_attack_position, 1);
      step();
      chk({tag, "_ack3"}, update_attack_position, 1);
      sync_attack_position = 1'b1;
      step();
      chk({tag, "_ackdrop"}, update_attack_position, 0);
      chk({tag, "_x"},   obj_x, ex);
      chk({tag, "_y"},   obj_y, ey);
      chk({tag, "_vis"}, obj_visible, 1);
      chk({tag, "_cen"}, obj_collide_en, 0);
   endtask

   task automatic tick_exp(input string tag, input int ex, input int ey, input bit ev, input bit ec);
      exp_t e;
      sb.push_back('{tag, 10'(ex), 10'(ey), ev, ec});
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      e = sb.pop_front();
      chk({e.tag, "_x"},   obj_x, e.x);
      chk({e.tag, "_y"},   obj_y, e.y);
      chk({e.tag, "_vis"}, obj_visible, e.vis);
      chk({e.tag, "_cen"}, obj_collide_en, e.col);
   endtask

   // WARN phase: stationary, collision enabled on the last warn tick.
   task automatic warn_phase(input string tag, input int x, input int y);
      for (int i = 1; i <= WARN_TICKS; i++)
         tick_exp(tag, x, y, 1'b1, i == WARN_TICKS);
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_ack", update_attack_position, 0);
      chk("rst_x", obj_x, 0);
      chk("rst_y", obj_y, 0);
      chk("rst_w", obj_w, 0);
      chk("rst_type", obj_type, 0);
      chk("rst_vis", obj_visible, 0);
      chk("rst_cen", obj_collide_en, 0);
      reset = 1'b0;
      step();

      // Move right speed 5 from x=100, never retires
      set_desc(5'h15, 2'd2, 3'd4, 5'd5, 10'd100, 10'd200, 10'd32, 10'd16, 8'd0, 2'd2);
      handshake("hs_r", 10'd100, 10'd200, 1'b0, 10'd0);
      warn_phase("warn_r", 100, 200);
      for (int k = 1; k <= 5; k++)
         tick_exp("mv_r", 100 + 5 * k, 200, 1'b1, 1'b1);

      // Edge retire: moving left past x=0 in one tick
      set_desc(5'h03, 2'd1, 3'd3, 5'd31, 10'd20, 10'd10, 10'd16, 10'd16, 8'd0, 2'd1);
      handshake("hs_l", 10'd20, 10'd10, 1'b0, 10'd0);
      warn_phase("warn_l", 20, 10);
      tick_exp("edge_l", 0, 10, 1'b0, 1'b0);
      tick_exp("idle_l", 0, 10, 1'b0, 1'b0);

      // Timer retire: destroy_time 2 -> 8 active ticks, moving down
      set_desc(5'h07, 2'd0, 3'd2, 5'd3, 10'd50, 10'd60, 10'd8, 10'd8, 8'd2, 2'd0);
      handshake("hs_t", 10'd50, 10'd60, 1'b0, 10'd0);
      warn_phase("warn_t", 50, 60);
      for (int k = 1; k <= 8; k++)
         tick_exp("timer", 50, 60 + 3 * k, k < 8, k < 8);
      tick_exp("timer_idle", 50, 84, 1'b0, 1'b0);

      // Oversized width pins x to 0; start y clamped; stationary edge retire
      set_desc(5'h01, 2'd3, 3'd0, 5'd0, 10'd100, 10'd470, 10'd700, 10'd20, 8'd0, 2'd1);
      handshake("hs_big", 10'd0, 10'd460, 1'b0, 10'd0);
      warn_phase("warn_big", 0, 460);
      tick_exp("big_retire", 0, 460, 1'b0, 1'b0);

      // Replace mid-ACTIVE with coincident frame_tick
      set_desc(5'h0A, 2'd1, 3'd6, 5'd2, 10'd300, 10'd300, 10'd10, 10'd10, 8'd0, 2'd2);
      handshake("hs_ur", 10'd300, 10'd300, 1'b0, 10'd0);
      warn_phase("warn_ur", 300, 300);
      for (int k = 1; k <= 3; k++)
         tick_exp("mv_ur", 300 + 2 * k, 300 - 2 * k, 1'b1, 1'b1);
      set_desc(5'h11, 2'd2, 3'd7, 5'd1, 10'd10, 10'd20, 10'd10, 10'd10, 8'd0, 2'd2);
      handshake("hs_rep", 10'd10, 10'd20, 1'b1, 10'd306);
      warn_phase("warn_rep", 10, 20);
      tick_exp("mv_rep", 11, 21, 1'b1, 1'b1);

      // Reset while ACTIVE with ack held high (sync kept low throughout)
      set_desc(5'h1F, 2'd3, 3'd4, 5'd4, 10'd200, 10'd100, 10'd20, 10'd20, 8'd5, 2'd3);
      sync_attack_position = 1'b0;
      step();
      chk("rr_ack", update_attack_position, 1);
      step();
      warn_phase("rr_warn", 200, 100);
      chk("rr_ack_held", update_attack_position, 1);
      reset = 1'b1;
      step();
      chk("rr_ack0", update_attack_position, 0);
      chk("rr_x", obj_x, 0);
      chk("rr_y", obj_y, 0);
      chk("rr_h", obj_h, 0);
      chk("rr_col", obj_colider, 0);
      chk("rr_vis", obj_visible, 0);
      chk("rr_cen", obj_collide_en, 0);
      sync_attack_position = 1'b1;
      reset = 1'b0;
      step();
      chk("rr_post_ack", update_attack_position, 0);
      chk("rr_post_vis", obj_visible, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
